// File: rtl/mem_access_unit.sv
// Multicycle data-memory sequencer: loads with sign/zero extension into MDR,
// sub-doubleword stores as read-modify-write, sd as a direct write.
module mem_access_unit #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [2:0]          off_q, off_d;
  logic                is_store_q, is_store_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                start_any;
  logic                req_bad;

  // Illegal funct3 for the direction, or offset not a multiple of the size.
  function automatic logic access_bad(input logic is_st, input logic [2:0] f3,
                                      input logic [2:0] off);
    logic       illegal;
    logic [2:0] mask;
    illegal = is_st ? f3[2] : (f3 == 3'b111);
    case (f3[1:0])
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return illegal || ((off & mask) != 3'b000);
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
                                                     input logic [2:0] f3,
                                                     input logic [2:0] off);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    s = w >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{56{s[7]}}, s[7:0]};
      3'b001:  r = {{48{s[15]}}, s[15:0]};
      3'b010:  r = {{32{s[31]}}, s[31:0]};
      3'b100:  r = {56'd0, s[7:0]};
      3'b101:  r = {48'd0, s[15:0]};
      3'b110:  r = {32'd0, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Replace the addressed bytes of the fetched word with the low store bytes.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] w,
                                                    input logic [DATA_W-1:0] sd,
                                                    input logic [2:0] f3,
                                                    input logic [2:0] off);
    logic [7:0]        bmask;
    logic [DATA_W-1:0] bitmask;
    case (f3[1:0])
      2'd0:    bmask = 8'h01;
      2'd1:    bmask = 8'h03;
      2'd2:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
    bmask = bmask << off;
    for (int i = 0; i < 8; i++) begin
      bitmask[8*i +: 8] = {8{bmask[i]}};
    end
    return (w & ~bitmask) | ((sd << {off, 3'b000}) & bitmask);
  endfunction

  assign start_any = start_read | start_write;
  assign req_bad   = access_bad(start_write, funct3, addr[2:0]);

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wdata_d    = wdata_q;
    mdr_d      = mdr_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_any) begin
          // start_write wins when both starts are raised together
          is_store_d = start_write;
          f3_d       = funct3;
          off_d      = addr[2:0];
          addr_d     = {addr[ADDR_W-1:3], 3'b000};
          sdata_d    = store_data;
          err_d      = req_bad;
          if (req_bad) begin
            state_d = S_DONE;
          end else if (start_write && funct3[1:0] == 2'b11) begin
            wdata_d = store_data;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (is_store_q) begin
            wdata_d = store_merge(mem_rdata, sdata_q, f3_q, off_q);
            state_d = S_WRITE;
          end else begin
            mdr_d   = load_extract(mem_rdata, f3_q, off_q);
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
      wdata_q    <= '0;
      mdr_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wdata_q    <= wdata_d;
      mdr_q      <= mdr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobes decode straight from state so a reset drops them in the same cycle.
  assign mem_rd    = (state_q == S_READ);
  assign mem_wr    = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mdr       = mdr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=3, each backed by its own behavioural memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_read, start_write, start_read3, start_write3;
  logic [2:0]  funct3;
  logic [63:0] addr, store_data;

  logic [63:0] mem_addr1, mem_wdata1, mem_rdata1, mdr1;
  logic        mem_rd1, mem_wr1, busy1, done1, err1;
  logic [63:0] mem_addr3, mem_wdata3, mem_rdata3, mdr3;
  logic        mem_rd3, mem_wr3, busy3, done3, err3;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_total1 = 0;

  logic [63:0] mem1 [logic [63:0]];
  logic [63:0] mem3 [logic [63:0]];
  logic [63:0] p3 [3];

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(64), .ADDR_W(64), .MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start_read(start_read), .start_write(start_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mdr(mdr1), .busy(busy1), .done(done1), .err(err1)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(64), .MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .start_read(start_read3), .start_write(start_write3),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .mdr(mdr3), .busy(busy3), .done(done3), .err(err3)
  );

  function automatic logic [63:0] rd_mem1(input logic [63:0] a);
    return mem1.exists(a) ? mem1[a] : 64'd0;
  endfunction

  function automatic logic [63:0] rd_mem3(input logic [63:0] a);
    return mem3.exists(a) ? mem3[a] : 64'd0;
  endfunction

  // Fixed-latency memories; rdata carries junk outside the valid cycle.
  always @(posedge clk) begin
    if (mem_wr1) begin
      mem1[mem_addr1] = mem_wdata1;
      wr_total1++;
    end
    mem_rdata1 <= mem_rd1 ? rd_mem1(mem_addr1) : 64'hDEAD_BEEF_DEAD_BEEF;
    if (mem_wr3) mem3[mem_addr3] = mem_wdata3;
    p3[0] <= mem_rd3 ? rd_mem3(mem_addr3) : 64'hBAD0_BAD0_BAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start in cycle 0, then watch strobes until done (bounded).
  task automatic run_op(input string tag, input bit sel3, input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] sd, input bit poke,
                        output int cyc, output int nrd, output int nwr,
                        output int wr_cyc, output logic [63:0] wdat,
                        output logic err_o);
    bit seen;
    logic r, w, d, e;
    logic [63:0] wd;
    cyc = 0; nrd = 0; nwr = 0; wr_cyc = -1; wdat = '0; err_o = 1'b0; seen = 1'b0;
    @(negedge clk);
    funct3 = f3; addr = a; store_data = sd;
    if (sel3) begin
      start_read3 = rd; start_write3 = wr;
    end else begin
      start_read = rd; start_write = wr;
    end
    for (int c = 1; c <= 30 && !seen; c++) begin
      @(negedge clk);
      start_read = 1'b0; start_write = 1'b0; start_read3 = 1'b0; start_write3 = 1'b0;
      if (poke && c <= 2) begin
        start_read  = c[0];
        start_write = ~c[0];
        funct3      = 3'b011;
        addr        = 64'h200;
      end
      r  = sel3 ? mem_rd3 : mem_rd1;
      w  = sel3 ? mem_wr3 : mem_wr1;
      d  = sel3 ? done3 : done1;
      e  = sel3 ? err3 : err1;
      wd = sel3 ? mem_wdata3 : mem_wdata1;
      if (r) nrd++;
      if (w) begin
        nwr++;
        wr_cyc = c;
        wdat = wd;
      end
      if (d) begin
        seen = 1'b1;
        cyc = c;
        err_o = e;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  int          cyc, nrd, nwr, wc, extra;
  logic [63:0] wd;
  logic        e;

  initial begin
    reset = 1'b1;
    start_read = 1'b0; start_write = 1'b0; start_read3 = 1'b0; start_write3 = 1'b0;
    funct3 = '0; addr = '0; store_data = '0;
    p3[0] = '0; p3[1] = '0; p3[2] = '0;
    mem1[64'h100] = 64'h8877_6655_4433_2211;
    mem3[64'h100] = 64'h8877_6655_4433_2211;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_strobes", 64'({mem_rd1, mem_wr1, done1, err1}), 64'd0);
    check("rst_mdr", mdr1, 64'd0);
    check("rst_addr_wdata", mem_addr1 | mem_wdata1, 64'd0);
    reset = 1'b0;

    run_op("ld", 0, 1, 0, 3'b011, 64'h100, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("ld_mdr", mdr1, 64'h8877_6655_4433_2211);
    check("ld_cycles", 64'(cyc), 64'd3);
    check("ld_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h10);
    check("ld_mem_addr", mem_addr1, 64'h100);

    run_op("lb", 0, 1, 0, 3'b000, 64'h107, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("lb_mdr", mdr1, 64'hFFFF_FFFF_FFFF_FF88);
    run_op("lbu", 0, 1, 0, 3'b100, 64'h107, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("lbu_mdr", mdr1, 64'h88);
    run_op("lh", 0, 1, 0, 3'b001, 64'h106, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("lh_mdr", mdr1, 64'hFFFF_FFFF_FFFF_8877);
    run_op("lwu", 0, 1, 0, 3'b110, 64'h104, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("lwu_mdr", mdr1, 64'h8877_6655);

    run_op("sb", 0, 0, 1, 3'b000, 64'h103, 64'hAB, 0, cyc, nrd, nwr, wc, wd, e);
    check("sb_wdata", wd, 64'h8877_6655_AB33_2211);
    check("sb_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h11);
    check("sb_cycles", 64'(cyc), 64'd4);
    check("sb_mdr_kept", mdr1, 64'h8877_6655);

    run_op("sh", 0, 0, 1, 3'b001, 64'h102, 64'hCDEF, 0, cyc, nrd, nwr, wc, wd, e);
    check("sh_wdata", wd, 64'h8877_6655_CDEF_2211);

    run_op("sd", 0, 0, 1, 3'b011, 64'h108, 64'h0123_4567_89AB_CDEF, 0, cyc, nrd, nwr, wc, wd, e);
    check("sd_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h01);
    check("sd_wr_cycle", 64'(wc), 64'd1);
    check("sd_wdata", wd, 64'h0123_4567_89AB_CDEF);
    check("sd_cycles", 64'(cyc), 64'd2);
    run_op("ld_back", 0, 1, 0, 3'b011, 64'h108, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("ld_back_mdr", mdr1, 64'h0123_4567_89AB_CDEF);

    run_op("lw_mis", 0, 1, 0, 3'b010, 64'h102, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("lw_mis_err", 64'(e), 64'd1);
    check("lw_mis_cycles", 64'(cyc), 64'd1);
    check("lw_mis_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h00);
    check("lw_mis_mdr", mdr1, 64'h0123_4567_89AB_CDEF);

    run_op("ld111", 0, 1, 0, 3'b111, 64'h100, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("ld111_err", 64'(e), 64'd1);
    check("ld111_cycles", 64'(cyc), 64'd1);
    check("ld111_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h00);
    @(negedge clk);
    check("err_hold", 64'(err1), 64'd1);

    run_op("st100", 0, 0, 1, 3'b100, 64'h100, 64'h55, 0, cyc, nrd, nwr, wc, wd, e);
    check("st100_err", 64'(e), 64'd1);
    check("st100_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h00);

    run_op("lbu_clr", 0, 1, 0, 3'b100, 64'h100, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("lbu_clr_err", 64'(e), 64'd0);
    check("lbu_clr_mdr", mdr1, 64'h11);

    run_op("both", 0, 1, 1, 3'b011, 64'h110, 64'hFEED, 0, cyc, nrd, nwr, wc, wd, e);
    check("both_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h01);
    check("both_wdata", wd, 64'hFEED);

    run_op("poke", 0, 1, 0, 3'b011, 64'h100, 0, 1, cyc, nrd, nwr, wc, wd, e);
    check("poke_strobes", 64'({nrd[3:0], nwr[3:0]}), 64'h10);
    check("poke_mdr", mdr1, 64'h8877_6655_CDEF_2211);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done1) extra++;
    end
    check("poke_extra_done", 64'(extra), 64'd0);
    check("poke_idle", 64'(busy1), 64'd0);

    // Abort an lb in WAIT with an asynchronous reset.
    @(negedge clk);
    funct3 = 3'b000; addr = 64'h107; start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    @(negedge clk);
    extra = wr_total1;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_strobes", 64'({mem_rd1, mem_wr1, done1}), 64'd0);
    check("abort_mdr", mdr1, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_write", 64'(wr_total1 - extra), 64'd0);
    check("abort_no_done", 64'(done1), 64'd0);

    run_op("ld_l3", 1, 1, 0, 3'b011, 64'h100, 0, 0, cyc, nrd, nwr, wc, wd, e);
    check("ld_l3_cycles", 64'(cyc), 64'd5);
    check("ld_l3_mdr", mdr3, 64'h8877_6655_4433_2211);
    run_op("sb_l3", 1, 0, 1, 3'b000, 64'h101, 64'h5A, 0, cyc, nrd, nwr, wc, wd, e);
    check("sb_l3_cycles", 64'(cyc), 64'd6);
    check("sb_l3_wdata", wd, 64'h8877_6655_4433_5A11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
